// File: rtl/countdown_timer.sv
// countdown_timer: BCD mm:ss countdown with an IDLE/RUN/PAUSED/DONE control FSM.
// Define TIMER_AUTO_RELOAD_EN to reload the last preset on expiry and keep running.
module countdown_timer #(
  parameter int MIN_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    load,
  input  logic [4*MIN_DIGITS-1:0] load_minute,
  input  logic [7:0]              load_second,
  input  logic                    start,
  input  logic                    pause,
  output logic [4*MIN_DIGITS-1:0] minute,
  output logic [7:0]              second,
  output logic                    running,
  output logic                    expired,
  output logic [1:0]              fsm_state
);

  localparam int MW = 4 * MIN_DIGITS;

  // fsm_state encoding: 0 IDLE, 1 RUN, 2 PAUSED, 3 DONE
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [MW-1:0]   minute_next, minute_dec, load_minute_clamped;
  logic [7:0]      second_next, second_dec, load_second_clamped;
  logic            expired_next;
  logic            count_zero, count_one;
  logic            dec_borrow;

`ifdef TIMER_AUTO_RELOAD_EN
  logic [MW-1:0]   reload_minute, reload_minute_next;
  logic [7:0]      reload_second, reload_second_next;
  logic            reload_zero;
  assign reload_zero = (reload_minute == '0) && (reload_second == 8'h00);
`endif

  assign count_zero = (minute == '0) && (second == 8'h00);
  assign count_one  = (minute == '0) && (second == 8'h01);
  assign running    = (state == RUN);
  assign fsm_state  = state;

  // Presets are forced back into legal BCD before they ever reach the count.
  always_comb begin
    load_minute_clamped = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      load_minute_clamped[4*i +: 4] = (load_minute[4*i +: 4] > 4'd9) ? 4'd9 : load_minute[4*i +: 4];
    end
    load_second_clamped[3:0] = (load_second[3:0] > 4'd9) ? 4'd9 : load_second[3:0];
    load_second_clamped[7:4] = (load_second[7:4] > 4'd5) ? 4'd5 : load_second[7:4];
  end

  // One-second BCD decrement; only consumed when the count is nonzero.
  always_comb begin
    second_dec = second;
    minute_dec = minute;
    dec_borrow = 1'b0;
    if (second[3:0] == 4'd0) begin
      second_dec[3:0] = 4'd9;
      dec_borrow      = 1'b1;
    end else begin
      second_dec[3:0] = second[3:0] - 4'd1;
    end
    if (dec_borrow) begin
      if (second[7:4] == 4'd0) begin
        second_dec[7:4] = 4'd5;
      end else begin
        second_dec[7:4] = second[7:4] - 4'd1;
        dec_borrow      = 1'b0;
      end
    end
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (dec_borrow) begin
        if (minute[4*i +: 4] == 4'd0) begin
          minute_dec[4*i +: 4] = 4'd9;
        end else begin
          minute_dec[4*i +: 4] = minute[4*i +: 4] - 4'd1;
          dec_borrow           = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_next   = state;
    minute_next  = minute;
    second_next  = second;
    expired_next = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
    reload_minute_next = reload_minute;
    reload_second_next = reload_second;
`endif
    if (load) begin
      minute_next = load_minute_clamped;
      second_next = load_second_clamped;
      state_next  = IDLE;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_minute_next = load_minute_clamped;
      reload_second_next = load_second_clamped;
`endif
    end else if (pause && state == RUN) begin
      state_next = PAUSED;
    end else if (start && (state == IDLE || state == PAUSED) && !count_zero) begin
      state_next = RUN;
    end else if (tick && state == RUN) begin
      if (count_zero) begin
        // Only reachable after an auto-reload expiry: this tick restarts the period.
`ifdef TIMER_AUTO_RELOAD_EN
        if (reload_zero) begin
          state_next = DONE;
        end else begin
          minute_next = reload_minute;
          second_next = reload_second;
        end
`else
        state_next = DONE;
`endif
      end else begin
        minute_next = minute_dec;
        second_next = second_dec;
        if (count_one) begin
          expired_next = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
          if (reload_zero) state_next = DONE;
`else
          state_next = DONE;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      minute  <= '0;
      second  <= 8'h00;
      expired <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_minute <= '0;
      reload_second <= 8'h00;
`endif
    end else begin
      state   <= state_next;
      minute  <= minute_next;
      second  <= second_next;
      expired <= expired_next;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_minute <= reload_minute_next;
      reload_second <= reload_second_next;
`endif
    end
  end

endmodule
